// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: issues one mult/div operation, stalls the pipeline until the unit is ready, then presents a one-cycle writeback (optional WAIT timeout via MULTDIV_TIMEOUT_EN)
module multdiv_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_is_div,
  input  logic [WIDTH-1:0] in_opA,
  input  logic [WIDTH-1:0] in_opB,
  input  logic [REG_W-1:0] in_rd,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic [WIDTH-1:0] md_opA,
  output logic [WIDTH-1:0] md_opB,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             stall,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_exception
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t           state;
  logic [REG_W-1:0] rd_q;
  logic             is_div_q;
`ifdef MULTDIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          expired;
  // cnt holds completed WAIT cycles, so the current WAIT cycle is number cnt+1
  assign expired = (cnt == CW'(TIMEOUT - 1));
`endif
  // strobes and writeback valid decode straight from the state register
  assign md_ctrl_mult = (state == ISSUE) & ~is_div_q;
  assign md_ctrl_div  = (state == ISSUE) & is_div_q;
  assign wb_valid     = (state == DONE);
  // stall is gated by reset so it drops immediately on an abort
  assign stall = ~reset & (((state == IDLE) & in_valid) | (state == ISSUE) | (state == WAIT));
  // issue/wait/writeback sequencing with operand and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      md_opA       <= '0;
      md_opB       <= '0;
      rd_q         <= '0;
      is_div_q     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          md_opA   <= in_opA;
          md_opB   <= in_opB;
          rd_q     <= in_rd;
          is_div_q <= in_is_div;
          state    <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
`ifdef MULTDIV_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: if (md_resultRDY) begin
          wb_data      <= md_result;
          wb_exception <= md_exception;
          wb_rd        <= rd_q;
          state        <= DONE;
        end
`ifdef MULTDIV_TIMEOUT_EN
        else if (expired) begin
          wb_data      <= '0;
          wb_exception <= 1'b1;
          wb_rd        <= rd_q;
          state        <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
